// File: rtl/ppu_pkg.sv
// Shared PPU timing types and NTSC default geometry for the frame timer and its helpers.
package ppu_pkg;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    POST    = 2'd1,
    VBLANK  = 2'd2,
    PRE     = 2'd3
  } ppu_phase_t;

  localparam int NTSC_H_TOTAL         = 341;
  localparam int NTSC_H_VISIBLE       = 256;
  localparam int NTSC_V_VISIBLE       = 240;
  localparam int NTSC_V_POST          = 1;
  localparam int NTSC_V_VBLANK        = 20;
  localparam int NTSC_V_TOTAL         = NTSC_V_VISIBLE + NTSC_V_POST + NTSC_V_VBLANK + 1;
  localparam int NTSC_VBLANK_SET_LINE = NTSC_V_VISIBLE + NTSC_V_POST;

  // Sprite evaluation for the next line runs from this dot to the end of the visible span.
  localparam int SPR_EVAL_FIRST_DOT   = 65;

  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ppu_vblank_nmi.sv
// VBLANK status flag with status-read race handling, and the registered active-low NMI output.
module ppu_vblank_nmi (
  input  logic clk,
  input  logic reset,
  input  logic set_evt,
  input  logic clr_evt,
  input  logic status_read,
  input  logic nmi_enable,
  output logic vblank_flag,
  output logic nmi_n
);

  logic vblank_q, vblank_d;
  logic nmi_n_q, nmi_n_d;

  // A read landing on the set cycle swallows the set, so that frame never raises NMI.
  always_comb begin
    vblank_d = vblank_q;
    if (set_evt && !status_read) begin
      vblank_d = 1'b1;
    end
    if (status_read) begin
      vblank_d = 1'b0;
    end else if (clr_evt) begin
      vblank_d = 1'b0;
    end
  end

  always_comb begin
    nmi_n_d = ~(vblank_q & nmi_enable);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vblank_q <= 1'b0;
      nmi_n_q  <= 1'b1;
    end else begin
      vblank_q <= vblank_d;
      nmi_n_q  <= nmi_n_d;
    end
  end

  assign vblank_flag = vblank_q;
  assign nmi_n       = nmi_n_q;

endmodule

// File: rtl/ppu_frame_timer.sv
// PPU dot/scanline counters, frame phase FSM, pipeline windows, line/frame strobes and VBLANK/NMI.
module ppu_frame_timer
  import ppu_pkg::*;
#(
  parameter int H_TOTAL     = NTSC_H_TOTAL,
  parameter int H_VISIBLE   = NTSC_H_VISIBLE,
  parameter int V_VISIBLE   = NTSC_V_VISIBLE,
  parameter int V_POST      = NTSC_V_POST,
  parameter int V_VBLANK    = NTSC_V_VBLANK,
  parameter bit ODD_SKIP_EN = 1'b1,
  parameter int CW          = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic          show_bg,
  input  logic          show_spr,
  input  logic          nmi_enable,
  input  logic          status_read,
  output logic [CW-1:0] dot,
  output logic [CW-1:0] scanline,
  output logic          render_active,
  output logic          fetch_en,
  output logic          spr_eval_en,
  output logic          vblank_flag,
  output logic          nmi_n,
  output logic          line_start,
  output logic          frame_done,
  output logic          odd_frame,
  output ppu_phase_t    phase_dbg
);

  localparam int V_TOTAL = V_VISIBLE + V_POST + V_VBLANK + 1;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_SKIP    = CW'(H_TOTAL - 2);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] VIS_LAST  = CW'(V_VISIBLE - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(V_VISIBLE + V_POST - 1);
  localparam logic [CW-1:0] VBL_LAST  = CW'(V_VISIBLE + V_POST + V_VBLANK - 1);
  localparam logic [CW-1:0] SET_LINE  = CW'(V_VISIBLE + V_POST);
  localparam logic [CW-1:0] DOT_ONE   = CW'(1);

  logic [CW-1:0] dot_q, dot_d;
  logic [CW-1:0] scanline_q, scanline_d;
  logic          odd_q, odd_d;
  logic          wrap_q, wrap_d;
  ppu_phase_t    phase_q, phase_d;

  logic on_last_line;
  logic odd_skip;
  logic line_wrap;
  logic frame_wrap;
  logic rendering;
  logic vbl_set_evt;
  logic vbl_clr_evt;

  assign rendering    = show_bg | show_spr;
  assign on_last_line = (scanline_q == V_LAST);

  // Odd-frame skip: the pre-render line ends one dot early, jumping straight to line 0 dot 0.
  assign odd_skip   = ODD_SKIP_EN && odd_q && rendering && on_last_line && (dot_q == H_SKIP);
  assign line_wrap  = pix_ce && ((dot_q == H_LAST) || odd_skip);
  assign frame_wrap = line_wrap && on_last_line;

  // Counter next-state; wrap_q remembers that the current 0/0 came from a frame wrap.
  always_comb begin
    dot_d      = dot_q;
    scanline_d = scanline_q;
    odd_d      = odd_q;
    wrap_d     = wrap_q;
    if (pix_ce) begin
      wrap_d = frame_wrap;
      if (line_wrap) begin
        dot_d      = '0;
        scanline_d = on_last_line ? '0 : scanline_q + 1'b1;
      end else begin
        dot_d = dot_q + 1'b1;
      end
      if (frame_wrap) begin
        odd_d = ~odd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dot_q      <= '0;
      scanline_q <= '0;
      odd_q      <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      dot_q      <= dot_d;
      scanline_q <= scanline_d;
      odd_q      <= odd_d;
      wrap_q     <= wrap_d;
    end
  end

  // Phase FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= VISIBLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase FSM: next state, stepping only on a line wrap.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      VISIBLE: if (line_wrap && scanline_q == VIS_LAST) phase_d = (V_POST == 0) ? VBLANK : POST;
      POST:    if (line_wrap && scanline_q == POST_LAST) phase_d = VBLANK;
      VBLANK:  if (line_wrap && scanline_q == VBL_LAST) phase_d = PRE;
      PRE:     if (frame_wrap) phase_d = VISIBLE;
      default: phase_d = VISIBLE;
    endcase
  end

  // Phase FSM: outputs. Strobes are forced low while reset is held.
  always_comb begin
    render_active = (phase_q == VISIBLE) && in_range(int'(dot_q), 1, H_VISIBLE);
    fetch_en      = ((phase_q == VISIBLE) || (phase_q == PRE)) && rendering;
    spr_eval_en   = (phase_q == VISIBLE) && show_spr &&
                    in_range(int'(dot_q), SPR_EVAL_FIRST_DOT, H_VISIBLE);
    line_start    = reset && pix_ce && (dot_q == '0);
    frame_done    = reset && pix_ce && wrap_q;
  end

  assign vbl_set_evt = pix_ce && (scanline_q == SET_LINE) && (dot_q == DOT_ONE);
  assign vbl_clr_evt = pix_ce && (phase_q == PRE) && (dot_q == DOT_ONE);

  ppu_vblank_nmi u_vblank_nmi (
    .clk         (clk),
    .reset       (reset),
    .set_evt     (vbl_set_evt),
    .clr_evt     (vbl_clr_evt),
    .status_read (status_read),
    .nmi_enable  (nmi_enable),
    .vblank_flag (vblank_flag),
    .nmi_n       (nmi_n)
  );

  assign dot       = dot_q;
  assign scanline  = scanline_q;
  assign odd_frame = odd_q;
  assign phase_dbg = phase_q;

endmodule
